seg_scan_display: RTL

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display_if.sv | 20 ++
 rtl/seg_scan_display.sv | 95 +++++++++
 2 files changed

// File: rtl/seg_scan_display_if.sv
// Store bus from the CPU data port to the seven-segment display window.
// Signals: wmem, DAddress, DataIn and memc go towards the display; hit and RdData come back.
interface seg_scan_display_if;
    logic        wmem;
    logic [15:0] DAddress;
    logic [15:0] DataIn;
    logic        memc;
    logic        hit;
    logic [15:0] RdData;

    modport master (
        output wmem, DAddress, DataIn, memc,
        input  hit, RdData
    );

    modport slave (
        input  wmem, DAddress, DataIn, memc,
        output hit, RdData
    );
endinterface

// File: rtl/seg_scan_display.sv
// Memory-mapped four-digit multiplexed seven-segment display driver.
// Ports: CLK, RESET (sync active-low), bus (store/readback), an (digit enables), seg (segments).
module seg_scan_display #(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter int          SCAN_DIV  = 50000
) (
    input  logic                CLK,
    input  logic                RESET,
    seg_scan_display_if.slave   bus,
    output logic [3:0]          an,
    output logic [7:0]          seg
);
    localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

    // Each digit: [3:0] hex value, [4] dp on, [5] blank.
    logic [5:0]  digit [4];
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [1:0]  off;
    logic [1:0]  lo;
    logic [1:0]  hi;
    logic        wrap;
    logic [5:0]  cur;
    logic [6:0]  pat;
    logic [7:0]  seg_d;
    logic        unused_data;

    // Low bits of the difference depend only on the low address bits.
    assign off = bus.DAddress[1:0] - BASE_ADDR[1:0];
    assign lo  = {off[1], 1'b0};
    assign hi  = {off[1], 1'b1};

    assign bus.hit = ({1'b0, bus.DAddress} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, bus.DAddress} <= ({1'b0, BASE_ADDR} + 17'd3));

    assign bus.RdData = {2'b00, digit[hi], 2'b00, digit[lo]};

    assign wrap = (cnt == LAST);

    assign unused_data = ^{bus.DataIn[15:14], bus.DataIn[7:6]};

    always_comb begin
        cur = digit[idx];
        pat = 7'h7F;
        case (cur[3:0])
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            4'hF: pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        seg_d = cur[5] ? 8'hFF : {~cur[4], pat};
    end

    // an/seg are sampled from the current index and digit contents, so they
    // trail both by one cycle; a write is visible one edge after it lands.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) begin
                digit[i] <= 6'b100000;
            end
            cnt <= '0;
            idx <= '0;
            an  <= 4'b1111;
            seg <= 8'hFF;
        end else begin
            cnt <= wrap ? '0 : cnt + 16'd1;
            if (wrap) begin
                idx <= idx + 2'd1;
            end
            an  <= ~(4'b0001 << idx);
            seg <= seg_d;
            if (bus.wmem && bus.hit) begin
                if (bus.memc) begin
                    digit[lo] <= bus.DataIn[5:0];
                    digit[hi] <= bus.DataIn[13:8];
                end else begin
                    digit[off] <= bus.DataIn[5:0];
                end
            end
        end
    end
endmodule
